// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to renderers.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
  logic       pix_tick;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  modport master (
    output pix_tick,
    output DrawX,
    output DrawY,
    output hs,
    output vs,
    output blank,
    output line_start,
`ifdef VGA_FRAME_COUNT_EN
    output frame_count,
`endif
    output frame_start
  );

  modport slave (
    input pix_tick,
    input DrawX,
    input DrawY,
    input hs,
    input vs,
    input blank,
    input line_start,
`ifdef VGA_FRAME_COUNT_EN
    input frame_count,
`endif
    input frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, H/V counters, registered syncs.
// Optional frame counter enabled by VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int PIX_DIV = 2
) (
  input  logic vga_clk,
  input  logic reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VEND = 10'(H_VIS);
  localparam logic [9:0] V_VEND = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] d;
  logic          tick;
  logic [9:0]    hc;
  logic [9:0]    vc;
  logic [9:0]    hc_nx;
  logic [9:0]    vc_nx;
  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  logic          ls_q;
  logic          fs_q;

  assign tick = (d == D_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      d <= '0;
    end else if (tick) begin
      d <= '0;
    end else begin
      d <= d + DW'(1);
    end
  end

  always_comb begin
    hc_nx = hc;
    vc_nx = vc;
    if (tick) begin
      if (hc == H_LAST) begin
        hc_nx = '0;
        if (vc == V_LAST) begin
          vc_nx = '0;
        end else begin
          vc_nx = vc + 10'd1;
        end
      end else begin
        hc_nx = hc + 10'd1;
      end
    end
  end

  // Decode from the next position so every flag lands with its coordinate.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc      <= '0;
      vc      <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      ls_q    <= 1'b1;
      fs_q    <= 1'b1;
    end else begin
      hc      <= hc_nx;
      vc      <= vc_nx;
      hs_q    <= !(hc_nx >= HS_BEG && hc_nx < HS_END);
      vs_q    <= !(vc_nx >= VS_BEG && vc_nx < VS_END);
      blank_q <= (hc_nx < H_VEND) && (vc_nx < V_VEND);
      ls_q    <= (hc_nx == '0);
      fs_q    <= (hc_nx == '0) && (vc_nx == '0);
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic        wrap;
  logic [15:0] fcnt;

  assign wrap = tick && (hc == H_LAST) && (vc == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      fcnt <= '0;
    end else if (wrap) begin
      fcnt <= fcnt + 16'd1;
    end
  end

  assign vga.frame_count = fcnt;
`endif

  assign vga.pix_tick    = tick;
  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size line timing on one instance, frame timing
// on a short-frame PIX_DIV=1 instance to keep run length small.
module tb_vga_timing_gen;
  logic vga_clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   passed = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();

  vga_timing_gen u_dut0 (
    .vga_clk (vga_clk),
    .reset   (rst0),
    .vga     (if0)
  );

  vga_timing_gen #(
    .V_VIS   (6),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (3),
    .PIX_DIV (1)
  ) u_dut1 (
    .vga_clk (vga_clk),
    .reset   (rst1),
    .vga     (if1)
  );

  localparam int V1_TOTAL = 13;
  localparam int FRAME1   = 800 * V1_TOTAL;

  logic [31:0] obs;
  logic [31:0] exp_v;

  task automatic test_reset();
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(negedge vga_clk);
    obs   = {if0.DrawX, if0.DrawY, if0.hs, if0.vs, if0.blank,
             if0.line_start, if0.frame_start, if0.pix_tick};
    exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v)
      $display("FAIL reset0 got %h exp %h", obs, exp_v);
    else passed++;
    obs   = {if1.DrawX, if1.DrawY, if1.hs, if1.vs, if1.blank,
             if1.line_start, if1.frame_start, if1.pix_tick};
    exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v)
      $display("FAIL reset1 got %h exp %h", obs, exp_v);
    else passed++;
`ifdef VGA_FRAME_COUNT_EN
    checks++;
    if (if1.frame_count !== 16'd0)
      $display("FAIL reset_fc got %0d exp 0", if1.frame_count);
    else passed++;
`endif
  endtask

  task automatic test_pix_tick();
    rst0 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      obs   = {20'd0, if0.DrawX, if0.pix_tick};
      exp_v = {20'd0, 10'(c / 2), 1'(c % 2)};
      checks++;
      if (obs !== exp_v)
        $display("FAIL tick c=%0d got %h exp %h", c, obs, exp_v);
      else passed++;
      @(negedge vga_clk);
    end
    rst0 = 1'b1;
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic test_line();
    int hs_low;
    int x;
    hs_low = 0;
    rst0 = 1'b0;
    for (int c = 0; c < 1600; c++) begin
      x = c / 2;
      obs   = {if0.DrawX, if0.DrawY, if0.hs, if0.blank,
               if0.line_start, if0.frame_start, if0.pix_tick};
      exp_v = {10'(x), 10'd0, 1'(!(x >= 656 && x < 752)),
               1'(x < 640), 1'(x == 0), 1'(x == 0), 1'(c % 2)};
      checks++;
      if (obs !== exp_v)
        $display("FAIL line c=%0d got %h exp %h", c, obs, exp_v);
      else passed++;
      if (c % 2 == 0 && if0.hs === 1'b0) hs_low++;
      @(negedge vga_clk);
    end
    checks++;
    if (hs_low != 96)
      $display("FAIL hs_width got %0d exp 96", hs_low);
    else passed++;
    obs   = {if0.DrawX, if0.DrawY, if0.line_start, if0.frame_start};
    exp_v = {10'd0, 10'd1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v)
      $display("FAIL line_wrap got %h exp %h", obs, exp_v);
    else passed++;
  endtask

  task automatic test_reset_midline();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (if0.DrawX == 10'd700) found = 1'b1;
      else @(negedge vga_clk);
    end
    checks++;
    if (!found || if0.hs !== 1'b0)
      $display("FAIL midline_reach found %0d hs %b exp hs 0", found, if0.hs);
    else passed++;
    rst0 = 1'b1;
    @(negedge vga_clk);
    obs   = {if0.DrawX, if0.DrawY, if0.hs, if0.vs, if0.blank,
             if0.line_start, if0.frame_start, if0.pix_tick};
    exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v)
      $display("FAIL midline_reset got %h exp %h", obs, exp_v);
    else passed++;
  endtask

  task automatic test_frame();
    int x;
    int y;
    int fc;
    x  = 0;
    y  = 0;
    fc = 0;
    rst1 = 1'b0;
    for (int c = 0; c < 3 * FRAME1; c++) begin
      obs   = {if1.DrawX, if1.DrawY, if1.hs, if1.vs, if1.blank,
               if1.line_start, if1.frame_start, if1.pix_tick};
      exp_v = {10'(x), 10'(y), 1'(!(x >= 656 && x < 752)),
               1'(!(y >= 8 && y < 10)), 1'(x < 640 && y < 6),
               1'(x == 0), 1'(x == 0 && y == 0), 1'b1};
      checks++;
      if (obs !== exp_v)
        $display("FAIL frame c=%0d got %h exp %h", c, obs, exp_v);
      else passed++;
`ifdef VGA_FRAME_COUNT_EN
      checks++;
      if (if1.frame_count !== 16'(fc))
        $display("FAIL fc c=%0d got %0d exp %0d", c, if1.frame_count, fc);
      else passed++;
`endif
      @(negedge vga_clk);
      if (x == 799) begin
        x = 0;
        if (y == V1_TOTAL - 1) begin
          y = 0;
          fc++;
        end else y++;
      end else x++;
    end
    obs   = {if1.DrawX, if1.DrawY, if1.frame_start};
    exp_v = {10'd0, 10'd0, 1'b1};
    checks++;
    if (obs !== exp_v || fc != 3)
      $display("FAIL frame_end got %h exp %h fc %0d", obs, exp_v, fc);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 12000 && !found; c++) begin
      if (if1.DrawX == 10'd700 && if1.DrawY == 10'd8) found = 1'b1;
      else @(negedge vga_clk);
    end
    checks++;
    if (!found || if1.hs !== 1'b0 || if1.vs !== 1'b0)
      $display("FAIL midframe_reach found %0d hs %b vs %b exp 0 0",
               found, if1.hs, if1.vs);
    else passed++;
    rst1 = 1'b1;
    @(negedge vga_clk);
    obs   = {if1.DrawX, if1.DrawY, if1.hs, if1.vs, if1.blank,
             if1.line_start, if1.frame_start, if1.pix_tick};
    exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v)
      $display("FAIL midframe_reset got %h exp %h", obs, exp_v);
    else passed++;
`ifdef VGA_FRAME_COUNT_EN
    checks++;
    if (if1.frame_count !== 16'd0)
      $display("FAIL midframe_fc got %0d exp 0", if1.frame_count);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_pix_tick();
    test_line();
    test_reset_midline();
    test_frame();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
